timer_dev: RTL

- Memory-mapped countdown timer that acts as the responder for CPU load/store accesses to one timer window (word offsets 0x0–0xB).
- The system bridge decodes the window and the CPU's memory stage; this block performs the register access and raises an interrupt request to CP0.
- Only whole-word accesses reach this block. Byte/half accesses and COUNT writes are trapped upstream as address exceptions.

---
 rtl/timer_dev.sv | 98 +++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a load/count/interrupt
// FSM and a level interrupt request gated by the CTRL mask bit.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'b00;
    localparam logic [1:0] A_PRESET = 2'b01;
    localparam logic [1:0] A_COUNT  = 2'b10;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;          // [3] IM, [2:1] MODE, [0] EN
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        pending, pending_nxt;
    logic        en_nxt;
    logic        ctrl_wr, preset_wr;

    assign ctrl_wr   = we && (addr == A_CTRL);
    assign preset_wr = we && (addr == A_PRESET);

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        pending_nxt = pending;
        en_nxt      = ctrl[0];
        case (state)
            IDLE: if (ctrl[0]) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // a preset of 0 expires exactly like a preset of 1
                    count_nxt   = 32'd0;
                    pending_nxt = 1'b1;
                    state_nxt   = INT;
                end
            end
            INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    pending_nxt = 1'b0;
                    state_nxt   = LOAD;
                end else begin
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ctrl    <= 4'd0;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            // a CTRL write overrides whatever the FSM would have done this edge
            if (ctrl_wr) begin
                ctrl    <= wdata[3:0];
                pending <= 1'b0;
                state   <= IDLE;
            end else begin
                state   <= state_nxt;
                count   <= count_nxt;
                pending <= pending_nxt;
                ctrl[0] <= en_nxt;
            end
            if (preset_wr) preset <= wdata;
        end
    end

    always_comb begin
        case (addr)
            A_CTRL:   rdata = {28'd0, ctrl};
            A_PRESET: rdata = preset;
            A_COUNT:  rdata = count;
            default:  rdata = 32'd0;
        endcase
    end

    assign irq = ctrl[3] & pending;
endmodule
